// File: rtl/bus_trace.sv
// Bus trace buffer: captures windowed CPU bus reads/writes with a timestamp into a
// first-word-fall-through ring, with overwrite, stop-when-full and triggered capture modes.
module bus_trace #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 16,
    parameter int STAMP_W = 16
) (
    input  logic                       trc_clk,
    input  logic                       trc_rst_n,
    input  logic                       trc_en,
    input  logic [1:0]                 trc_mode,
    input  logic                       trc_clr,
    input  logic [ADDR_W-1:0]          trc_addr_lo,
    input  logic [ADDR_W-1:0]          trc_addr_hi,
    input  logic [ADDR_W-1:0]          bus_addr,
    input  logic [DATA_W-1:0]          bus_wdata,
    input  logic [DATA_W-1:0]          bus_rdata,
    input  logic                       bus_rd,
    input  logic                       bus_wr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_we,
    output logic [ADDR_W-1:0]          out_addr,
    output logic [DATA_W-1:0]          out_data,
    output logic [STAMP_W-1:0]         out_stamp,
    output logic [$clog2(DEPTH):0]     trc_count,
    output logic                       trc_full,
    output logic [15:0]                trc_ovf_cnt,
    output logic                       trc_trig,
    output logic                       trc_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic               we;
        logic [ADDR_W-1:0]  addr;
        logic [DATA_W-1:0]  data;
        logic [STAMP_W-1:0] stamp;
    } entry_t;

    entry_t             mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic [STAMP_W-1:0] stamp_q;
    logic [15:0]        ovf_q, ovf_d;
    logic               trig_q, trig_d, err_q, err_d;

    logic   in_win, evt, trig_hit, full, pop, cap, overwrite, write, drop, rd_adv;
    entry_t new_ent, head;

    always_comb begin
        in_win    = (bus_addr >= trc_addr_lo) && (bus_addr <= trc_addr_hi);
        evt       = (bus_rd | bus_wr) & in_win;
        trig_hit  = bus_wr && (bus_addr == trc_addr_lo);
        full      = (count_q == CW'(DEPTH));
        pop       = (count_q != '0) && out_ready;
        cap       = 1'b0;
        case (trc_mode)
            2'd1, 2'd2: cap = trc_en & evt;
            2'd3:       cap = trc_en & (trig_q ? evt : trig_hit);
            default:    cap = 1'b0;
        endcase
        // When full with no pop, mode 1 evicts the oldest; modes 2/3 drop the newcomer.
        overwrite = cap & full & ~pop & (trc_mode == 2'd1);
        drop      = cap & full & ~pop & ~overwrite;
        write     = cap & ~drop;
        rd_adv    = pop | overwrite;

        wr_ptr_d  = wr_ptr_q + AW'(write);
        rd_ptr_d  = rd_ptr_q + AW'(rd_adv);
        count_d   = count_q + CW'(write) - CW'(rd_adv);
        ovf_d     = ((drop | overwrite) && ovf_q != 16'hFFFF) ? ovf_q + 16'd1 : ovf_q;
        trig_d    = trig_q | (cap & (trc_mode == 2'd3));
        err_d     = err_q | (evt & bus_rd & bus_wr);

        new_ent.we    = bus_wr;
        new_ent.addr  = bus_addr;
        new_ent.data  = bus_wr ? bus_wdata : bus_rdata;
        new_ent.stamp = stamp_q;

        if (trc_clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = '0;
            trig_d   = 1'b0;
            err_d    = 1'b0;
        end
    end

    always_ff @(posedge trc_clk or negedge trc_rst_n) begin
        if (!trc_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            stamp_q  <= '0;
            ovf_q    <= '0;
            trig_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            stamp_q  <= stamp_q + STAMP_W'(1);
            ovf_q    <= ovf_d;
            trig_q   <= trig_d;
            err_q    <= err_d;
        end
    end

    // Storage needs no reset: outputs are masked whenever the buffer is empty.
    always_ff @(posedge trc_clk) begin
        if (write && !trc_clr) mem_q[wr_ptr_q] <= new_ent;
    end

    always_comb begin
        head      = mem_q[rd_ptr_q];
        out_valid = (count_q != '0);
        out_we    = out_valid ? head.we    : 1'b0;
        out_addr  = out_valid ? head.addr  : '0;
        out_data  = out_valid ? head.data  : '0;
        out_stamp = out_valid ? head.stamp : '0;
    end

    assign trc_count   = count_q;
    assign trc_full    = full;
    assign trc_ovf_cnt = ovf_q;
    assign trc_trig    = trig_q;
    assign trc_err     = err_q;
endmodule

// File: tb/tb_bus_trace.sv
// Bench for bus_trace: queue-based reference model compared every cycle, plus
// hand-computed checkpoints for the capture modes, clear and reset behaviour.
module tb_bus_trace;
    localparam int AW = 32, DW = 32, DEPTH = 16, SW = 16;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          en, clr, rd, wr, ready;
    logic [1:0]    mode;
    logic [AW-1:0] lo, hi, addr;
    logic [DW-1:0] wdata, rdata;
    logic          out_valid, out_we, full, trig, err;
    logic [AW-1:0] out_addr;
    logic [DW-1:0] out_data;
    logic [SW-1:0] out_stamp;
    logic [$clog2(DEPTH):0] count;
    logic [15:0]   ovf;

    bus_trace #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .STAMP_W(SW)) dut (
        .trc_clk(clk), .trc_rst_n(rst_n), .trc_en(en), .trc_mode(mode), .trc_clr(clr),
        .trc_addr_lo(lo), .trc_addr_hi(hi), .bus_addr(addr), .bus_wdata(wdata),
        .bus_rdata(rdata), .bus_rd(rd), .bus_wr(wr), .out_valid(out_valid),
        .out_ready(ready), .out_we(out_we), .out_addr(out_addr), .out_data(out_data),
        .out_stamp(out_stamp), .trc_count(count), .trc_full(full), .trc_ovf_cnt(ovf),
        .trc_trig(trig), .trc_err(err));

    always #5 clk = ~clk;

    typedef struct {
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [SW-1:0] stamp;
    } ent_t;

    ent_t        q[$];
    int          m_ovf;
    bit          m_trig, m_err;
    logic [SW-1:0] m_stamp;
    int          n_pass = 0, n_total = 0;
    bit          cmp_en = 1'b0;

    task automatic model_reset();
        q.delete();
        m_ovf = 0; m_trig = 0; m_err = 0; m_stamp = '0;
    endtask

    task automatic model_step();
        bit   pop, cap;
        ent_t e;
        pop = (q.size() != 0) && ready;
        if (clr) begin
            q.delete();
            m_ovf = 0; m_trig = 0; m_err = 0;
        end else begin
            bit ev;
            ev  = (rd || wr) && (addr >= lo) && (addr <= hi);
            if (ev && rd && wr) m_err = 1;
            cap = 0;
            if (mode == 2'd1 || mode == 2'd2) cap = en && ev;
            else if (mode == 2'd3) begin
                cap = m_trig ? (en && ev) : (en && wr && addr == lo);
                if (cap) m_trig = 1;
            end
            e.we = wr; e.addr = addr; e.data = wr ? wdata : rdata; e.stamp = m_stamp;
            if (pop) void'(q.pop_front());
            if (cap) begin
                if (q.size() < DEPTH) q.push_back(e);
                else begin
                    if (mode == 2'd1) begin
                        void'(q.pop_front());
                        q.push_back(e);
                    end
                    if (m_ovf < 65535) m_ovf++;
                end
            end
        end
        m_stamp = m_stamp + 1'b1;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", n, act, exp);
        else n_pass++;
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("valid", out_valid, q.size() != 0);
            if (q.size() != 0) begin
                chk("we", out_we, q[0].we);
                chk("addr", out_addr, q[0].addr);
                chk("data", out_data, q[0].data);
                chk("stamp", out_stamp, q[0].stamp);
            end
            chk("count", count, q.size());
            chk("full", full, q.size() == DEPTH);
            chk("ovf", ovf, m_ovf);
            chk("trig", trig, m_trig);
            chk("err", err, m_err);
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic drive(input bit r, input bit w, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input logic [DW-1:0] rdv);
        rd = r; wr = w; addr = a; wdata = wd; rdata = rdv;
    endtask

    task automatic idle();
        drive(0, 0, '0, '0, '0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
    endtask

    initial begin
        en = 1; mode = 2'd2; clr = 0; lo = 32'h0; hi = 32'hFF; ready = 0;
        idle();
        #2;
        chk("rst_valid", out_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_stamp", out_stamp, 0);
        cmp_en = 1'b1;
        do_reset();

        // stop-when-full: first 16 of 20 writes kept
        for (int i = 0; i < 20; i++) begin drive(0, 1, 32'h10, i, 0); step(); end
        idle();
        chk("m2_count", count, 16);
        chk("m2_full", full, 1);
        chk("m2_ovf", ovf, 4);
        chk("m2_head_addr", out_addr, 32'h10);
        chk("m2_head_stamp", out_stamp, 0);

        // overwrite-oldest: last 16 kept
        mode = 2'd1;
        do_reset();
        for (int i = 0; i < 20; i++) begin drive(0, 1, 32'h10, i, 0); step(); end
        idle();
        chk("m1_count", count, 16);
        chk("m1_ovf", ovf, 4);
        chk("m1_head_stamp", out_stamp, 4);
        chk("m1_head_data", out_data, 4);

        // push and pop on the same edge while full
        ready = 1; drive(0, 1, 32'h11, 32'h99, 0); step();
        ready = 0; idle();
        chk("pp_count", count, 16);
        chk("pp_ovf", ovf, 4);
        chk("pp_head_stamp", out_stamp, 5);

        // triggered capture
        mode = 2'd3; lo = 32'h40; hi = 32'hFF;
        do_reset();
        drive(1, 0, 32'h40, 0, 32'h11); step();
        drive(1, 0, 32'h44, 0, 32'h22); step();
        chk("m3_pre_trig", trig, 0);
        chk("m3_pre_count", count, 0);
        drive(0, 1, 32'h40, 32'hAA, 0); step();
        drive(1, 0, 32'h44, 0, 32'h55); step();
        step();
        idle();
        chk("m3_trig", trig, 1);
        chk("m3_count", count, 3);
        chk("m3_we", out_we, 1);
        chk("m3_addr", out_addr, 32'h40);
        chk("m3_data", out_data, 32'hAA);
        chk("m3_stamp", out_stamp, 2);

        // window boundaries, enable, inverted window, mode 0 drain
        clr = 1; step(); clr = 0;
        chk("clr_trig", trig, 0);
        mode = 2'd2; lo = 32'h10; hi = 32'h20;
        drive(0, 1, 32'h0F, 1, 0); step();
        drive(0, 1, 32'h10, 2, 0); step();
        drive(1, 0, 32'h20, 0, 3); step();
        drive(0, 1, 32'h21, 4, 0); step();
        en = 0; drive(0, 1, 32'h15, 5, 0); step(); en = 1;
        lo = 32'h30; drive(0, 1, 32'h25, 6, 0); step(); lo = 32'h10;
        mode = 2'd0; drive(0, 1, 32'h15, 7, 0); step();
        idle();
        chk("win_count", count, 2);
        chk("win_head_addr", out_addr, 32'h10);
        ready = 1; step(); step(); ready = 0;
        chk("drain_count", count, 0);

        // both strobes: recorded as write, sticky error, cleared by clr
        mode = 2'd1; lo = 32'h0; hi = 32'hFF;
        drive(1, 1, 32'h20, 32'h1234, 32'h5678); step();
        idle();
        chk("both_we", out_we, 1);
        chk("both_data", out_data, 32'h1234);
        chk("both_err", err, 1);
        clr = 1; step(); clr = 0;
        chk("clr_err", err, 0);
        chk("clr_valid", out_valid, 0);

        // mixed traffic with intermittent consumer
        for (int i = 0; i < 40; i++) begin
            ready = (i % 3 == 0);
            mode  = (i < 20) ? 2'd1 : 2'd2;
            drive(i % 2, (i % 5) != 1, 32'h80 + i, 32'h1000 + i, 32'h2000 + i);
            step();
        end
        ready = 0; idle();

        // asynchronous reset mid-stream
        mode = 2'd1;
        do_reset();
        clr = 1; step(); clr = 0;
        for (int i = 0; i < 5; i++) begin drive(0, 1, 32'h30 + i, i, 0); step(); end
        idle();
        chk("pre_rst_count", count, 5);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_count", count, 0);
        chk("arst_addr", out_addr, 0);
        chk("arst_data", out_data, 0);
        chk("arst_stamp", out_stamp, 0);
        chk("arst_we", out_we, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(0, 1, 32'h30, 32'h77, 0); step();
        idle();
        chk("post_rst_count", count, 1);
        chk("post_rst_addr", out_addr, 32'h30);
        chk("post_rst_stamp", out_stamp, 0);
        step();
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
